uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 47 ++++
 rtl/uart_sync_fifo.sv | 61 ++++++
 rtl/uart_rx_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller: FSM states,
// register map, STATUS/CTRL bit positions and the reset baud divisor.
package uart_pkg;

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned BRD_W   = 16;
  localparam int unsigned REG_W   = 32;
  localparam int unsigned ADDR_W  = 2;

  // 50 MHz system clock, 9600 baud
  localparam logic [BRD_W-1:0] BRD_RST_DEFAULT = 16'd5208;

  localparam logic [ADDR_W-1:0] ADDR_DATA   = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_BRD    = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd3;

  localparam int unsigned STS_NOT_EMPTY = 0;
  localparam int unsigned STS_FULL      = 1;
  localparam int unsigned STS_FRAME_ERR = 2;
  localparam int unsigned STS_OVERRUN   = 3;
  localparam int unsigned STS_COUNT_LSB = 4;
  localparam int unsigned STS_COUNT_W   = 5;

  localparam int unsigned CTRL_RX_EN  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_ACK,
    ST_WAIT_CLR
  } rx_state_e;

  // Frame as delivered by the receiver, start bit in the LSB
  typedef struct packed {
    logic              stop;
    logic [DATA_W-1:0] data;
    logic              start;
  } rx_frame_t;

  function automatic logic frame_bad(input rx_frame_t f);
    return f.start | ~f.stop;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO for received bytes. A push into a full FIFO only lands
// when a pop happens in the same cycle; a pop from an empty FIFO is ignored.
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             full_q;
  logic             empty_q;
  logic             do_push_c;
  logic             do_pop_c;

  assign do_pop_c  = pop & ~empty_q;
  assign do_push_c = push & (~full_q | do_pop_c);
  assign count_d   = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr_q] <= din;
  end

  assign dout  = mem[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: captures frames from the receiver into a byte
// FIFO and exposes DATA/STATUS/BRD/CTRL registers plus a level interrupt.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned      DEPTH   = 4,
  parameter logic [BRD_W-1:0] BRD_RST = BRD_RST_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_done,
  input  logic [FRAME_W-1:0] rx_frame,
  output logic               rx_get,
  output logic [BRD_W-1:0]   brd,
  input  logic               cs,
  input  logic               we,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [REG_W-1:0]   wdata,
  output logic [REG_W-1:0]   rdata,
  output logic               irq
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  rx_state_e          state_q;
  rx_state_e          state_d;
  rx_frame_t          frame_q;
  logic               capture_c;
  logic               push_c;
  logic               rx_get_q;

  logic               rx_en_q;
  logic               irq_en_q;
  logic               frame_err_q;
  logic               overrun_q;
  logic [BRD_W-1:0]   brd_q;
  logic [REG_W-1:0]   rdata_q;
  logic               irq_q;

  logic               rd_c;
  logic               wr_c;
  logic               pop_c;
  logic               ferr_set_c;
  logic               ovr_set_c;
  logic               sts_wr_c;
  logic [REG_W-1:0]   status_c;
  logic [REG_W-1:0]   rd_word_c;

  logic [DATA_W-1:0]  fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CNT_W-1:0]   fifo_count;

  // Only the low half of wdata carries register fields
  logic               unused_wdata;
  assign unused_wdata = ^wdata[REG_W-1:BRD_W];

  assign rd_c       = cs & ~we;
  assign wr_c       = cs & we;
  assign pop_c      = rd_c & (addr == ADDR_DATA) & ~fifo_empty;
  assign sts_wr_c   = wr_c & (addr == ADDR_STATUS);
  assign ferr_set_c = push_c & frame_bad(frame_q);
  assign ovr_set_c  = push_c & fifo_full & ~pop_c;

  // Frame handshake state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      rx_get_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rx_get_q <= (state_d == ST_ACK);
    end
  end

  always_comb begin
    state_d   = state_q;
    capture_c = 1'b0;
    push_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_en_q && rx_done) begin
          capture_c = 1'b1;
          state_d   = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        push_c  = 1'b1;
        state_d = ST_ACK;
      end
      ST_ACK: begin
        state_d = ST_WAIT_CLR;
      end
      ST_WAIT_CLR: begin
        if (!rx_done) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q <= '0;
    end else if (capture_c) begin
      frame_q <= rx_frame_t'(rx_frame);
    end
  end

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .din   (frame_q.data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky flags: a set event in the same cycle beats a write-1-to-clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= ferr_set_c | (frame_err_q & ~(sts_wr_c & wdata[STS_FRAME_ERR]));
      overrun_q   <= ovr_set_c  | (overrun_q   & ~(sts_wr_c & wdata[STS_OVERRUN]));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      brd_q    <= BRD_RST;
      rx_en_q  <= 1'b1;
      irq_en_q <= 1'b0;
    end else if (wr_c) begin
      if (addr == ADDR_BRD && wdata[BRD_W-1:0] != '0) begin
        brd_q <= wdata[BRD_W-1:0];
      end
      if (addr == ADDR_CTRL) begin
        rx_en_q  <= wdata[CTRL_RX_EN];
        irq_en_q <= wdata[CTRL_IRQ_EN];
      end
    end
  end

  always_comb begin
    status_c                                  = '0;
    status_c[STS_NOT_EMPTY]                   = ~fifo_empty;
    status_c[STS_FULL]                        = fifo_full;
    status_c[STS_FRAME_ERR]                   = frame_err_q;
    status_c[STS_OVERRUN]                     = overrun_q;
    status_c[STS_COUNT_LSB +: STS_COUNT_W]    = STS_COUNT_W'(fifo_count);
  end

  always_comb begin
    rd_word_c = '0;
    case (addr)
      ADDR_DATA: begin
        if (!fifo_empty) rd_word_c = REG_W'(fifo_dout);
      end
      ADDR_STATUS: rd_word_c = status_c;
      ADDR_BRD:    rd_word_c = REG_W'(brd_q);
      ADDR_CTRL: begin
        rd_word_c[CTRL_RX_EN]  = rx_en_q;
        rd_word_c[CTRL_IRQ_EN] = irq_en_q;
      end
      default: rd_word_c = '0;
    endcase
  end

  // Read data and interrupt are registered; rdata holds between reads
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      if (rd_c) rdata_q <= rd_word_c;
      irq_q <= irq_en_q & (~fifo_empty | frame_err_q | overrun_q);
    end
  end

  assign rx_get = rx_get_q;
  assign brd    = brd_q;
  assign rdata  = rdata_q;
  assign irq    = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: a queue-based model predicts register
// reads, and a monitor compares rdata on the cycle after each read.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int unsigned DEPTH   = 4;
  localparam logic [15:0] BRD_RST = 16'd5208;
  localparam int          TMO     = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_done = 1'b0;
  logic [9:0]  rx_frame = '0;
  logic        rx_get;
  logic [15:0] brd;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  mq[$];
  bit          m_ferr = 0;
  bit          m_ovr = 0;
  bit          m_rx_en = 1;
  bit          m_irq_en = 0;
  logic [15:0] m_brd = BRD_RST;
  logic [31:0] exp_q[$];
  logic        rd_seen;

  uart_rx_ctrl #(.DEPTH(DEPTH), .BRD_RST(BRD_RST)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_done  (rx_done),
    .rx_frame (rx_frame),
    .rx_get   (rx_get),
    .brd      (brd),
    .cs       (cs),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    int s;
    s = mq.size() * 16 + (m_ovr ? 8 : 0) + (m_ferr ? 4 : 0)
      + ((mq.size() == DEPTH) ? 2 : 0) + ((mq.size() != 0) ? 1 : 0);
    return 32'(s);
  endfunction

  function automatic logic model_irq();
    return m_irq_en && (mq.size() != 0 || m_ferr || m_ovr);
  endfunction

  task automatic model_push(input logic [9:0] f);
    if (f[0] || !f[9]) m_ferr = 1;
    if (mq.size() < DEPTH) mq.push_back(f[8:1]);
    else m_ovr = 1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ferr = 0; m_ovr = 0; m_rx_en = 1; m_irq_en = 0; m_brd = BRD_RST;
  endtask

  // Monitor: rdata is valid on the cycle after a sampled read
  always @(posedge clk or negedge rst) begin
    if (!rst) rd_seen <= 1'b0;
    else      rd_seen <= cs & ~we;
  end

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rdata_unexpected: got 0x%08h with no expected entry", rdata);
      end else begin
        check("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  // All driver tasks start and end just after a falling edge
  task automatic lsu_read(input logic [1:0] a);
    logic [31:0] e;
    case (a)
      2'd0: e = (mq.size() != 0) ? {24'h0, mq.pop_front()} : 32'h0;
      2'd1: e = model_status();
      2'd2: e = {16'h0, m_brd};
      default: e = {30'h0, m_irq_en, m_rx_en};
    endcase
    exp_q.push_back(e);
    cs = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0;
  endtask

  task automatic lsu_write(input logic [1:0] a, input logic [31:0] d);
    case (a)
      2'd1: begin
        if (d[2]) m_ferr = 0;
        if (d[3]) m_ovr = 0;
      end
      2'd2: if (d[15:0] != 16'h0) m_brd = d[15:0];
      2'd3: begin
        m_rx_en  = d[0];
        m_irq_en = d[1];
      end
      default: ;
    endcase
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic wait_get(output int n);
    n = 0;
    while (!rx_get && n < TMO) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic complete_frame(input logic [9:0] f, input bit upd);
    @(negedge clk);
    check("rx_get_pulse_width", {31'h0, rx_get}, 32'h0);
    rx_done = 1'b0;
    @(negedge clk);
    if (upd) model_push(f);
  endtask

  task automatic send_frame(input logic [9:0] f);
    int n;
    rx_frame = f; rx_done = 1'b1;
    wait_get(n);
    check("rx_get_latency", 32'(n), 32'd2);
    if (rx_get) complete_frame(f, 1'b1);
    else begin
      rx_done = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic check_irq();
    @(negedge clk);
    check("irq", {31'h0, irq}, {31'h0, model_irq()});
  endtask

  initial begin
    logic [9:0] f;
    int         n;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_rx_get", {31'h0, rx_get}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);
    check("reset_brd", {16'h0, brd}, {16'h0, BRD_RST});
    rst = 1'b1;
    lsu_read(2'd3);
    lsu_read(2'd1);

    // Clean frame carrying 0xA5
    send_frame(10'b1_1010_0101_0);
    lsu_read(2'd1);
    lsu_read(2'd0);
    lsu_read(2'd0);

    // Stop bit 0: byte still stored, frame_err set then cleared
    send_frame({1'b0, 8'h3C, 1'b0});
    lsu_read(2'd1);
    lsu_write(2'd1, 32'h4);
    lsu_read(2'd1);
    lsu_read(2'd0);

    // Five frames into a 4-deep FIFO: fifth dropped, overrun set
    for (int i = 0; i < 5; i++) send_frame({1'b1, 8'(8'h10 + i), 1'b0});
    lsu_read(2'd1);
    for (int i = 0; i < 4; i++) lsu_read(2'd0);
    lsu_read(2'd1);
    lsu_write(2'd1, 32'hC);

    // Full FIFO with a push and a DATA pop landing on the same edge
    for (int i = 0; i < 4; i++) send_frame({1'b1, 8'(8'h50 + i), 1'b0});
    f = {1'b1, 8'h77, 1'b0};
    rx_frame = f; rx_done = 1'b1;
    @(negedge clk);
    exp_q.push_back({24'h0, mq.pop_front()});
    mq.push_back(8'h77);
    cs = 1'b1; we = 1'b0; addr = 2'd0;
    @(negedge clk);
    cs = 1'b0;
    check("concurrent_rx_get", {31'h0, rx_get}, 32'h1);
    complete_frame(f, 1'b0);
    lsu_read(2'd1);
    for (int i = 0; i < 4; i++) lsu_read(2'd0);
    lsu_read(2'd0);

    // Baud divisor, writes of zero ignored, DATA writes ignored
    lsu_write(2'd2, 32'h0000_00A2);
    check("brd_write", {16'h0, brd}, {16'h0, m_brd});
    lsu_write(2'd2, 32'h0);
    check("brd_zero_ignored", {16'h0, brd}, 32'h0000_00A2);
    lsu_read(2'd2);
    lsu_write(2'd0, 32'h55);
    lsu_read(2'd1);

    // Interrupt follows not_empty when enabled
    lsu_write(2'd3, 32'h3);
    check_irq();
    send_frame({1'b1, 8'hE1, 1'b0});
    check_irq();
    lsu_read(2'd0);
    check_irq();

    // Disabling rx_en on the capture edge still completes that frame
    f = {1'b1, 8'h2B, 1'b0};
    rx_frame = f; rx_done = 1'b1;
    lsu_write(2'd3, 32'h0);
    wait_get(n);
    check("disable_mid_frame_rx_get", {31'h0, rx_get}, 32'h1);
    if (rx_get) complete_frame(f, 1'b1);
    else begin rx_done = 1'b0; @(negedge clk); end
    // No capture while disabled
    rx_frame = {1'b1, 8'h99, 1'b0}; rx_done = 1'b1;
    wait_get(n);
    check("no_capture_disabled", {31'h0, rx_get}, 32'h0);
    rx_done = 1'b0;
    @(negedge clk);
    lsu_read(2'd1);
    lsu_read(2'd0);
    lsu_write(2'd3, 32'h1);

    // Randomized mix of frames and register traffic
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0, 1: send_frame({1'($urandom_range(0, 7) != 0), 8'($urandom),
                          1'($urandom_range(0, 7) == 0)});
        2: lsu_read(2'd0);
        3: lsu_read(2'($urandom_range(1, 3)));
        4: lsu_write(2'd1, 32'($urandom_range(0, 3)) << 2);
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            lsu_write(2'd2, ($urandom_range(0, 3) == 0) ? 32'h0 : 32'($urandom));
            check("brd_random", {16'h0, brd}, {16'h0, m_brd});
          end else begin
            lsu_write(2'd3, {30'h0, 1'($urandom_range(0, 1)), 1'b1});
          end
        end
      endcase
      check_irq();
    end
    while (mq.size() != 0) lsu_read(2'd0);
    lsu_read(2'd1);

    // Reset asserted during ACK aborts; held rx_done is recaptured
    f = {1'b1, 8'hC3, 1'b0};
    rx_frame = f; rx_done = 1'b1;
    wait_get(n);
    rst = 1'b0;
    #1;
    check("rst_ack_rx_get", {31'h0, rx_get}, 32'h0);
    check("rst_ack_rdata", rdata, 32'h0);
    check("rst_ack_brd", {16'h0, brd}, {16'h0, BRD_RST});
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    lsu_read(2'd1);
    wait_get(n);
    check("recapture_after_reset", {31'h0, rx_get}, 32'h1);
    if (rx_get) complete_frame(f, 1'b1);
    else begin rx_done = 1'b0; @(negedge clk); end
    lsu_read(2'd3);
    lsu_read(2'd0);
    lsu_read(2'd1);

    @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
